// File: rtl/scan_ctrl.sv
// -----------------------------------------------------------------------------
// scan_ctrl
//   Moves words between a streaming interface and an external serial scan
//   chain. Each transaction shifts exactly CHAIN_LEN bits through the chain.
//   The bits are grouped into words of up to WORD_W bits, LSB first. For each
//   word, a write word is accepted, shifted out on scan_in_o, and the bits
//   returned on scan_out_i are offered as a read word.
//
//   Optional feature (macro SCAN_CTRL_PARITY_EN):
//     When defined, parity_o is the running XOR of every scan_out_i bit
//     sampled in the current or most recent transaction.
//     When undefined, parity_o is tied to 0.
//
// Parameters
//   CHAIN_LEN  number of flops in the attached chain (>=1)
//   WORD_W     data word width (>=1)
//
// Ports
//   clk, rst_n             clock; asynchronous active-low reset
//   start_i                begin a transaction (honoured only in IDLE)
//   wdata_i/wvalid_i/
//   wready_o               write-word handshake
//   rdata_o/rvalid_o/
//   rready_i               read-word handshake
//   scan_en_o, scan_in_o,
//   scan_out_i             chain shift enable, serial out, serial in
//   busy_o, done_o         transaction active; one-cycle end pulse
//   parity_o               parity of the captured bits (see macro above)
// -----------------------------------------------------------------------------
module scan_ctrl #(
    parameter int CHAIN_LEN = 9,
    parameter int WORD_W    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic [WORD_W-1:0] wdata_i,
    input  logic              wvalid_i,
    output logic              wready_o,
    output logic [WORD_W-1:0] rdata_o,
    output logic              rvalid_o,
    input  logic              rready_i,
    output logic              scan_en_o,
    output logic              scan_in_o,
    input  logic              scan_out_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              parity_o
);

    localparam int CW = $clog2(CHAIN_LEN + 1);
    localparam int NW = $clog2(WORD_W + 1);

    typedef enum logic [2:0] {IDLE, LOAD, SHIFT, STORE, DONE} state_t;

    state_t            state;
    logic [CW-1:0]     bits_left;   // chain bits still to shift in this transaction
    logic [NW-1:0]     word_n;      // bits carried by the current word
    logic [NW-1:0]     cnt;         // shifts still to do for the current word
    logic [WORD_W-1:0] shreg;
    logic [WORD_W-1:0] shift_nxt;

    // Number of bits in the next word: a full word, or the remaining tail.
    function automatic logic [NW-1:0] word_bits(input logic [CW-1:0] left);
        if (32'(left) < WORD_W) word_bits = NW'(left);
        else                    word_bits = NW'(WORD_W);
    endfunction

    // Shift right by one. The captured bit lands at position n-1, so that after
    // n shifts bit k holds the k-th captured bit. Positions >= n are forced to
    // 0, which flushes unused write bits out of a short tail word.
    function automatic logic [WORD_W-1:0] shift_word(input logic [WORD_W-1:0] cur,
                                                     input logic              din,
                                                     input logic [NW-1:0]     n);
        logic [WORD_W-1:0] sh;
        logic [WORD_W-1:0] r;
        sh = cur >> 1;
        for (int i = 0; i < WORD_W; i++) begin
            if (i < int'(n) - 1)       r[i] = sh[i];
            else if (i == int'(n) - 1) r[i] = din;
            else                       r[i] = 1'b0;
        end
        return r;
    endfunction

    assign shift_nxt = shift_word(shreg, scan_out_i, word_n);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            bits_left <= '0;
            word_n    <= '0;
            cnt       <= '0;
            shreg     <= '0;
            rdata_o   <= '0;
            wready_o  <= 1'b0;
            rvalid_o  <= 1'b0;
            scan_en_o <= 1'b0;
            scan_in_o <= 1'b0;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        state     <= LOAD;
                        bits_left <= CW'(CHAIN_LEN);
                        busy_o    <= 1'b1;
                        wready_o  <= 1'b1;
                    end
                end
                LOAD: begin
                    if (wvalid_i) begin
                        state     <= SHIFT;
                        shreg     <= wdata_i;
                        word_n    <= word_bits(bits_left);
                        cnt       <= word_bits(bits_left);
                        wready_o  <= 1'b0;
                        scan_en_o <= 1'b1;
                        // scan_in_o is registered, so present bit 0 of the new word now
                        scan_in_o <= wdata_i[0];
                    end
                end
                SHIFT: begin
                    shreg     <= shift_nxt;
                    cnt       <= cnt - 1'b1;
                    bits_left <= bits_left - 1'b1;
                    if (cnt == NW'(1)) begin
                        state     <= STORE;
                        scan_en_o <= 1'b0;
                        scan_in_o <= 1'b0;
                        rvalid_o  <= 1'b1;
                        rdata_o   <= shift_nxt;
                    end else begin
                        scan_in_o <= shift_nxt[0];
                    end
                end
                STORE: begin
                    if (rready_i) begin
                        rvalid_o <= 1'b0;
                        if (bits_left != '0) begin
                            state    <= LOAD;
                            wready_o <= 1'b1;
                        end else begin
                            state  <= DONE;
                            done_o <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    done_o <= 1'b0;
                    busy_o <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SCAN_CTRL_PARITY_EN
    logic parity_q;

    // Cleared only when a new transaction is accepted, so the result of the
    // last transaction stays visible while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                        parity_q <= 1'b0;
        else if (state == IDLE && start_i) parity_q <= 1'b0;
        else if (state == SHIFT)           parity_q <= parity_q ^ scan_out_i;
    end

    assign parity_o = parity_q;
`else
    assign parity_o = 1'b0;
`endif

endmodule
